// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: walks the memory through idle arbiter slots, writes back
// words with a correctable single-bit error and logs/interrupts on uncorrectable ones.
module ecc_scrub_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned INTERVAL = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear_counts,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [6:0]        mem_wparity,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic [6:0]        mem_rparity,
    output logic              busy,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic              ded_irq,
    output logic [ADDR_W-1:0] ded_addr,
    output logic              sweep_done
);

    localparam int unsigned TMR_W = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(INTERVAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Hsiao check matrix: data column j is the j-th 7-bit value of weight 3, so any
    // single error gives an odd-weight syndrome and any double error an even one.
    function automatic logic [32*7-1:0] gen_cols();
        logic [32*7-1:0] cols;
        int n;
        int w;
        cols = '0;
        n    = 0;
        for (int v = 0; v < 128; v++) begin
            w = 0;
            for (int b = 0; b < 7; b++) begin
                w += (v >> b) & 1;
            end
            if (w == 3 && n < 32) begin
                cols[n*7 +: 7] = v[6:0];
                n++;
            end
        end
        return cols;
    endfunction

    localparam logic [32*7-1:0] H_COLS = gen_cols();

    typedef enum logic [2:0] {
        StIdle, StWait, StRdReq, StRdWait, StCheck, StWrReq, StNext
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [6:0]         rparity_q, rparity_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [6:0]         wparity_q, wparity_d;
    logic [CNT_W-1:0]   sec_q, sec_d;
    logic [CNT_W-1:0]   ded_q, ded_d;
    logic [ADDR_W-1:0]  ded_addr_q, ded_addr_d;
    logic               ded_irq_q, ded_irq_d;
    logic               sweep_done_q, sweep_done_d;

    logic [6:0]  syndrome;
    logic [31:0] cor_data;
    logic [6:0]  cor_parity;
    logic        single_error;
    logic        double_error;

    // Correction/detection of the registered word.
    always_comb begin
        syndrome = rparity_q;
        for (int j = 0; j < 32; j++) begin
            if (rdata_q[j]) syndrome = syndrome ^ H_COLS[j*7 +: 7];
        end
        cor_data     = rdata_q;
        cor_parity   = rparity_q;
        single_error = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (syndrome == H_COLS[j*7 +: 7]) begin
                cor_data[j]  = ~rdata_q[j];
                single_error = 1'b1;
            end
        end
        for (int k = 0; k < 7; k++) begin
            if (syndrome == 7'(1 << k)) begin
                cor_parity[k] = ~rparity_q[k];
                single_error  = 1'b1;
            end
        end
        double_error = (syndrome != '0) && !single_error;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        timer_d      = timer_q;
        rdata_d      = rdata_q;
        rparity_d    = rparity_q;
        wdata_d      = wdata_q;
        wparity_d    = wparity_q;
        sec_d        = sec_q;
        ded_d        = ded_q;
        ded_addr_d   = ded_addr_q;
        ded_irq_d    = 1'b0;
        sweep_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWait;
                    timer_d = TMR_LOAD;
                end
            end
            StWait: begin
                if (timer_q == '0) state_d = StRdReq;
                else               timer_d = timer_q - TMR_W'(1);
            end
            StRdReq: begin
                if (mem_gnt) state_d = StRdWait;
            end
            StRdWait: begin
                if (mem_rvalid) begin
                    rdata_d   = mem_rdata;
                    rparity_d = mem_rparity;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (double_error) begin
                    if (ded_q != '1) ded_d = ded_q + CNT_W'(1);
                    ded_addr_d = addr_q;
                    ded_irq_d  = 1'b1;
                    state_d    = StNext;
                end else if (single_error) begin
                    if (sec_q != '1) sec_d = sec_q + CNT_W'(1);
                    wdata_d   = cor_data;
                    wparity_d = cor_parity;
                    state_d   = StWrReq;
                end else begin
                    state_d = StNext;
                end
            end
            StWrReq: begin
                if (mem_gnt) state_d = StNext;
            end
            StNext: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d       = '0;
                    sweep_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (enable) begin
                    state_d = StWait;
                    timer_d = TMR_LOAD;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A same-cycle increment is deliberately dropped.
        if (clear_counts) begin
            sec_d = '0;
            ded_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            timer_q      <= '0;
            rdata_q      <= '0;
            rparity_q    <= '0;
            wdata_q      <= '0;
            wparity_q    <= '0;
            sec_q        <= '0;
            ded_q        <= '0;
            ded_addr_q   <= '0;
            ded_irq_q    <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            timer_q      <= timer_d;
            rdata_q      <= rdata_d;
            rparity_q    <= rparity_d;
            wdata_q      <= wdata_d;
            wparity_q    <= wparity_d;
            sec_q        <= sec_d;
            ded_q        <= ded_d;
            ded_addr_q   <= ded_addr_d;
            ded_irq_q    <= ded_irq_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign mem_req     = (state_q == StRdReq) || (state_q == StWrReq);
    assign mem_we      = (state_q == StWrReq);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wparity = wparity_q;
    assign busy        = (state_q != StIdle);
    assign sec_count   = sec_q;
    assign ded_count   = ded_q;
    assign ded_irq     = ded_irq_q;
    assign ded_addr    = ded_addr_q;
    assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: a memory/arbiter model replays accesses against
// a scoreboard of expected reads and write-backs, plus counter and control-edge checks.
module tb_ecc_scrub_ctrl;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned INTERVAL = 5;
    localparam int unsigned CNT_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              clear_counts = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [6:0]        mem_wparity;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [6:0]        mem_rparity = '0;
    logic              busy;
    logic [CNT_W-1:0]  sec_count;
    logic [CNT_W-1:0]  ded_count;
    logic              ded_irq;
    logic [ADDR_W-1:0] ded_addr;
    logic              sweep_done;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .INTERVAL(INTERVAL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear_counts(clear_counts),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wparity (mem_wparity),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rparity (mem_rparity),
        .busy        (busy),
        .sec_count   (sec_count),
        .ded_count   (ded_count),
        .ded_irq     (ded_irq),
        .ded_addr    (ded_addr),
        .sweep_done  (sweep_done)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [6:0]        wparity;
    } acc_t;

    acc_t        exp_q[$];
    int          rd_cyc[$];
    logic [38:0] mem [16];
    int          vectors = 0;
    int          miscompares = 0;
    int          deny_rd = 0;
    int          deny_wr = 0;
    bit          sticky = 1'b0;
    int          sweep_pulses = 0;
    int          ded_pulses = 0;
    int          cyc = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_rd(input int a);
        acc_t e;
        e = '{we: 1'b0, addr: ADDR_W'(a), wdata: 32'h0, wparity: 7'h0};
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input int a, input logic [31:0] d, input logic [6:0] p);
        acc_t e;
        e = '{we: 1'b1, addr: ADDR_W'(a), wdata: d, wparity: p};
        exp_q.push_back(e);
    endtask

    task automatic wait_size(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (exp_q.size() > target && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy), 64'(0));
    endtask

    // Arbiter + memory model, driven on the falling edge; a grant given here is
    // taken by the DUT at the next rising edge and serviced on the falling edge after.
    task automatic responder();
        bit   acc_pend;
        bit   holding;
        acc_t acc;
        acc_t snap;
        acc_t want;
        acc_pend = 1'b0;
        holding  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            if (acc_pend) begin
                acc_pend = 1'b0;
                chk("access_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    chk("acc_we", 64'(acc.we), 64'(want.we));
                    chk("acc_addr", 64'(acc.addr), 64'(want.addr));
                    if (want.we) begin
                        chk("acc_wdata", 64'(acc.wdata), 64'(want.wdata));
                        chk("acc_wparity", 64'(acc.wparity), 64'(want.wparity));
                    end
                end
                if (acc.we) begin
                    if (!sticky) mem[acc.addr] = {acc.wdata, acc.wparity};
                end else begin
                    mem_rvalid = 1'b1;
                    {mem_rdata, mem_rparity} = mem[acc.addr];
                    last_rd_addr = acc.addr;
                    rd_cyc.push_back(cyc);
                end
            end
            if (sweep_done === 1'b1) begin
                sweep_pulses++;
                chk("sweep_after_last", 64'(last_rd_addr), 64'(DEPTH - 1));
            end
            if (ded_irq === 1'b1) ded_pulses++;
            mem_gnt = 1'b0;
            if (mem_req === 1'b1) begin
                if (mem_we ? (deny_wr > 0) : (deny_rd > 0)) begin
                    if (holding) begin
                        chk("hold_addr", 64'(mem_addr), 64'(snap.addr));
                        chk("hold_we", 64'(mem_we), 64'(snap.we));
                        chk("hold_wdata", 64'(mem_wdata), 64'(snap.wdata));
                        chk("hold_wparity", 64'(mem_wparity), 64'(snap.wparity));
                    end else begin
                        holding = 1'b1;
                        snap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata,
                                 wparity: mem_wparity};
                    end
                    if (mem_we) deny_wr--;
                    else        deny_rd--;
                end else begin
                    mem_gnt  = 1'b1;
                    acc_pend = 1'b1;
                    holding  = 1'b0;
                    acc = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wparity: mem_wparity};
                end
            end else begin
                holding = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        fork
            responder();
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_wparity", 64'(mem_wparity), 64'(0));
        chk("rst_sec", 64'(sec_count), 64'(0));
        chk("rst_ded", 64'(ded_count), 64'(0));
        chk("rst_ded_irq", 64'(ded_irq), 64'(0));
        chk("rst_ded_addr", 64'(ded_addr), 64'(0));
        chk("rst_sweep", 64'(sweep_done), 64'(0));
        rst_n = 1'b1;
        tick();

        // Clean sweep: reads 0..3 then 0 again, one wrap pulse, 6 WAIT cycles per word
        rd_cyc.delete();
        sweep_pulses = 0;
        for (int a = 0; a < 4; a++) exp_rd(a);
        exp_rd(0);
        enable = 1'b1;
        wait_size("p1_drain", 0, 300);
        enable = 1'b0;
        wait_idle("p1_idle");
        chk("p1_sec", 64'(sec_count), 64'(0));
        chk("p1_ded", 64'(ded_count), 64'(0));
        chk("p1_sweep_pulses", 64'(sweep_pulses), 64'(1));
        chk("p1_reads", 64'(rd_cyc.size()), 64'(5));
        for (int i = 1; i < rd_cyc.size(); i++)
            chk("p1_word_period", 64'(rd_cyc[i] - rd_cyc[i-1]), 64'(10));
        chk("p1_addr", 64'(mem_addr), 64'(1));

        // Parity error @1, data error @2, double error @3, over two sweeps
        mem[1] = {32'h0, 7'h01};
        mem[2] = {32'h1, 7'h00};
        mem[3] = {32'h3, 7'h00};
        ded_pulses = 0;
        exp_rd(1); exp_wr(1, 32'h0, 7'h0);
        exp_rd(2); exp_wr(2, 32'h0, 7'h0);
        exp_rd(3); exp_rd(0); exp_rd(1); exp_rd(2); exp_rd(3);
        enable = 1'b1;
        wait_size("p2_drain", 0, 400);
        enable = 1'b0;
        wait_idle("p2_idle");
        chk("p2_sec", 64'(sec_count), 64'(2));
        chk("p2_ded", 64'(ded_count), 64'(2));
        chk("p2_ded_addr", 64'(ded_addr), 64'(3));
        chk("p2_ded_pulses", 64'(ded_pulses), 64'(2));
        chk("p2_addr", 64'(mem_addr), 64'(0));

        // Grant withheld 7 cycles on both the read and the write-back
        mem[0] = {32'h0001_0000, 7'h00};
        deny_rd = 7;
        deny_wr = 7;
        exp_rd(0); exp_wr(0, 32'h0, 7'h0);
        enable = 1'b1;
        wait_size("p3_drain", 0, 300);
        enable = 1'b0;
        wait_idle("p3_idle");
        chk("p3_rd_stalled", 64'(deny_rd), 64'(0));
        chk("p3_wr_stalled", 64'(deny_wr), 64'(0));
        chk("p3_sec", 64'(sec_count), 64'(3));
        chk("p3_addr", 64'(mem_addr), 64'(1));

        // Enable dropped in RD_WAIT: the word finishes, address advances
        exp_rd(1);
        enable = 1'b1;
        wait_size("p4_drain", 0, 100);
        enable = 1'b0;
        wait_idle("p4_idle");
        repeat (20) tick();
        chk("p4_busy", 64'(busy), 64'(0));
        chk("p4_req", 64'(mem_req), 64'(0));
        chk("p4_addr", 64'(mem_addr), 64'(2));

        // clear_counts in the CHECK cycle of a single error wins over the increment
        mem[2] = {32'h1, 7'h00};
        exp_rd(2); exp_wr(2, 32'h0, 7'h0);
        enable = 1'b1;
        wait_size("p5_read", 1, 100);
        tick();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        chk("p5_sec_cleared", 64'(sec_count), 64'(0));
        chk("p5_ded_cleared", 64'(ded_count), 64'(0));
        wait_size("p5_drain", 0, 100);
        enable = 1'b0;
        wait_idle("p5_idle");
        chk("p5_sec", 64'(sec_count), 64'(0));
        chk("p5_ded_addr", 64'(ded_addr), 64'(3));
        chk("p5_addr", 64'(mem_addr), 64'(3));

        // Eight single errors into a 3-bit counter: saturates at 7
        sticky = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = {32'h4, 7'h00};
        for (int k = 0; k < 8; k++) begin
            exp_rd((3 + k) % 4);
            exp_wr((3 + k) % 4, 32'h0, 7'h0);
        end
        enable = 1'b1;
        wait_size("p6_drain", 0, 600);
        enable = 1'b0;
        wait_idle("p6_idle");
        sticky = 1'b0;
        chk("p6_sec_sat", 64'(sec_count), 64'(7));
        chk("p6_addr", 64'(mem_addr), 64'(3));

        // Reset while a write-back waits for grant
        mem[3] = {32'h1, 7'h00};
        deny_wr = 1000;
        exp_rd(3);
        enable = 1'b1;
        wait_size("p7_read", 0, 100);
        tick();
        tick();
        chk("p7_wr_req", 64'(mem_req), 64'(1));
        chk("p7_wr_we", 64'(mem_we), 64'(1));
        chk("p7_wr_addr", 64'(mem_addr), 64'(3));
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        chk("p7_req", 64'(mem_req), 64'(0));
        chk("p7_busy", 64'(busy), 64'(0));
        chk("p7_sec", 64'(sec_count), 64'(0));
        chk("p7_ded", 64'(ded_count), 64'(0));
        chk("p7_ded_addr", 64'(ded_addr), 64'(0));
        chk("p7_addr", 64'(mem_addr), 64'(0));
        chk("p7_wdata", 64'(mem_wdata), 64'(0));
        deny_wr = 0;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("p7_stays_idle", 64'(mem_req), 64'(0));
        chk("end_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background memory scrubber for the 32-bit + 7-bit SECDED-protected data memory. It walks the memory address by address and reads each word and its parity. Each word goes through an internal correction_detection instance. Single-bit errors (in data or parity) are written back corrected; double-bit errors are logged and raised as an interrupt. Memory access goes through a req/gnt port on the memory arbiter, where functional traffic has priority and the scrubber only uses idle slots.

Parameters:
ADDR_W, 8, memory address width
DEPTH, 256, number of words scrubbed per sweep; must be ≤ 2^ADDR_W
INTERVAL, 1024, idle cycles between word scrubs (0 allowed)
CNT_W, 16, width of the error counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  scrubbing enable, level
clear_counts  in  1  synchronous clear of sec_count and ded_count
mem_req  out  1  memory access request
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  access address
mem_wdata  out  32  corrected data for write
mem_wparity  out  7  corrected parity for write
mem_gnt  in  1  arbiter grant; the access is accepted in a cycle where mem_req & mem_gnt
mem_rvalid  in  1  read return valid, at least 1 cycle after the grant
mem_rdata  in  32  read data
mem_rparity  in  7  read parity
busy  out  1  high in every state except IDLE
sec_count  out  CNT_W  saturating count of corrected single errors
ded_count  out  CNT_W  saturating count of double errors
ded_irq  out  1  1-cycle pulse per double error
ded_addr  out  ADDR_W  address of the most recent double error
sweep_done  out  1  1-cycle pulse when the address wraps DEPTH-1 → 0

Behaviour:
- Reset (rst_n=0 at an edge, in any state):
  - state=IDLE; scrub address=0; timer=0; both counters=0; ded_addr=0.
  - mem_req, mem_we, ded_irq, sweep_done, busy = 0; mem_wdata/mem_wparity = 0.
  - An access that is in flight is abandoned; a late mem_rvalid in IDLE is ignored.
- FSM states: IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
- IDLE: if enable=1 → WAIT and load timer=INTERVAL.
- WAIT: if timer==0 → RD_REQ, else decrement. WAIT therefore lasts INTERVAL+1 cycles.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=scrub address. Held stable until mem_gnt=1, then → RD_WAIT.
- RD_WAIT: on mem_rvalid, register mem_rdata/mem_rparity → CHECK. mem_req=0.
- CHECK: the registered word drives correction_detection combinationally.
  - double_error=1 (takes priority even if single_error is also set): ded_count += 1 (saturating at all-ones), ded_addr=scrub address, ded_irq=1 for 1 cycle on the next edge → NEXT. No write.
  - single_error=1 only: sec_count += 1 (saturating); latch sec_corrected_data/parity into mem_wdata/mem_wparity → WR_REQ.
  - Neither flag: → NEXT.
- WR_REQ: mem_req=1, mem_we=1, same address. Held stable until mem_gnt → NEXT.
- NEXT:
  - If address==DEPTH-1: address=0 and sweep_done pulses 1 cycle. Otherwise address += 1.
  - Then → WAIT (reload timer) if enable=1, else → IDLE.
- enable deasserted mid-word: the current word completes, including any pending write-back. The block then stops in IDLE at NEXT. The address is retained, so re-enabling resumes at the next word.
- clear_counts:
  - Zeroes both counters at the edge and has priority over a same-cycle increment; that increment is lost.
  - ded_irq and ded_addr are unaffected.
- Minimum latency per clean word (gnt immediate, rvalid 1 cycle after grant): RD_REQ 1 + RD_WAIT 1 + CHECK 1 + NEXT 1 = 4 cycles after WAIT. A corrected word adds ≥1 WR_REQ cycle.
- Outputs are registered except mem_addr/mem_we/mem_req, which are decoded from the state register and the address register. These remain glitch-free per cycle.

Test Plan:
- Clean sweep: DEPTH=4, INTERVAL=0, all words data 0/parity 0, gnt tied 1, rvalid 1 cycle after grant. Expect:
  - 4 reads, no writes, counters 0.
  - sweep_done pulses once after the addr-3 read, then addr 0 is read again.
- Single data error: addr 2 holds data 32'h1 / parity 7'b0000000. Expect a write to addr 2 with data 32'h0 / parity 7'b0000000, sec_count=1, no ded_irq.
- Single parity error: addr 1 holds data 32'h0 / parity 7'b0000001. Expect a write with data 32'h0 / parity 7'b0000000, sec_count=1.
- Double error: addr 3 holds data 32'h3 / parity 0. Expect:
  - no write, ded_count=1, ded_addr=3, ded_irq high for exactly 1 cycle.
  - The next sweep repeats this, giving ded_count=2.
- Arbitration/timing: INTERVAL=5, gnt held 0 for 7 cycles during RD_REQ and again during WR_REQ. Expect:
  - mem_req/mem_addr/mem_we/mem_wdata stable throughout.
  - 6 WAIT cycles between words.
  - The single-error write still completes.
- Control edges, each checked separately:
  - Drop enable during RD_WAIT: the word completes → IDLE, busy=0, address advanced by 1.
  - Assert rst_n=0 during WR_REQ: mem_req=0 the next cycle and all counters 0.
  - Assert clear_counts in the CHECK cycle of a single error: sec_count=0.
  - With sec_count preset to all-ones, a further error keeps sec_count at all-ones.
